seg7_scan_driver: RTL and testbench

Output-side companion to the board's button/switch debouncer. It latches a 16-bit hex value plus per-digit decimal-point, blank and blink masks, and time-multiplexes them onto the board's 4-digit common-anode seven-segment display. Both the anode and segment outputs are active-low. It sits between the datapath result registers and the display pins, and runs off the same system clock as the debouncer.

---
 rtl/seg7_scan_driver.sv | 116 +++++++++++
 tb/tb_seg7_scan_driver.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with per-digit decimal point,
// blank and blink masks. AN and SEGMENT are active-low and registered.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  input  logic [3:0]  blink,
  output logic [3:0]  AN,
  output logic [7:0]  SEGMENT
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C   = CNT_W'(GUARD);
  localparam logic [7:0]       FRAME_MAX = 8'(BLINK_FRAMES - 1);

  logic [15:0]      data_q;
  logic [3:0]       dp_q;
  logic [3:0]       blank_q;
  logic [3:0]       blink_q;
  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       idx;
  logic [7:0]       frame_cnt;
  logic             blink_phase;

  logic             scan_wrap;
  logic             frame_wrap;
  logic             dark;
  logic [3:0]       nib_p0;
  logic [3:0]       an_p0;
  logic [7:0]       seg_p0;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign scan_wrap  = (scan_cnt == CNT_MAX);
  assign frame_wrap = scan_wrap && (idx == 2'd3);

  // Stage p0: next-output selection from the current scan state.
  always_comb begin
    nib_p0 = data_q[{idx, 2'b00} +: 4];
    dark   = blank_q[idx] | (blink_q[idx] & blink_phase);
    an_p0  = 4'hF;
    seg_p0 = 8'hFF;
    if ((scan_cnt >= GUARD_C) && !dark) begin
      an_p0  = ~(4'b0001 << idx);
      seg_p0 = {~dp_q[idx], hex_decode(nib_p0)};
    end
  end

  // Stage p1: capture, scan/blink timing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      dp_q        <= '0;
      blank_q     <= '0;
      blink_q     <= '0;
      scan_cnt    <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      AN          <= 4'hF;
      SEGMENT     <= 8'hFF;
    end else begin
      if (load) begin
        data_q  <= data;
        dp_q    <= dp;
        blank_q <= blank;
        blink_q <= blink;
      end
      scan_cnt <= scan_wrap ? '0 : scan_cnt + CNT_W'(1);
      if (scan_wrap) begin
        idx <= idx + 2'd1;
      end
      if (frame_wrap) begin
        if (frame_cnt == FRAME_MAX) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
      AN      <= an_p0;
      SEGMENT <= seg_p0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  blink;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;

  int checks   = 0;
  int failures = 0;
  int k        = 0;

  seg7_scan_driver #(
    .SCAN_DIV    (4),
    .GUARD       (1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .data   (data),
    .dp     (dp),
    .blank  (blank),
    .blink  (blink),
    .AN     (AN),
    .SEGMENT(SEGMENT)
  );

  always #5 clk = ~clk;

  // Repeating AN sequence after the two dark cycles following reset release.
  logic [3:0] an_pat [16] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                              4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [31:0] segs;   // {digit3, digit2, digit1, digit0} lit SEGMENT values
  } vec_t;

  vec_t vecs [5];

  localparam logic [31:0] ALL_C0 = 32'hC0C0C0C0;

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic check(input string name, input logic [3:0] ea, input logic [7:0] es);
    checks++;
    if (AN !== ea || SEGMENT !== es) begin
      failures++;
      $display("FAIL %s k=%0d AN=%h SEGMENT=%h expected AN=%h SEGMENT=%h",
               name, k, AN, SEGMENT, ea, es);
    end
  endtask

  // Expected outputs at sample k (k=0 is the sample right after the last reset edge).
  function automatic void expect_out(input int kk, input logic [31:0] segs,
                                     input logic [3:0] bl, input logic [3:0] bk,
                                     output logic [3:0] ea, output logic [7:0] es);
    int p;
    int d;
    int frame;
    logic phase;
    ea = 4'hF;
    es = 8'hFF;
    if (kk < 2) return;
    p = (kk - 2) % 16;
    case (an_pat[p])
      4'hE: d = 0;
      4'hD: d = 1;
      4'hB: d = 2;
      4'h7: d = 3;
      default: return;
    endcase
    frame = (kk - 1) / 16;
    phase = ((frame / 2) % 2) == 1;
    if (bl[d] || (bk[d] && phase)) return;
    ea = an_pat[p];
    es = segs[d*8 +: 8];
  endfunction

  task automatic run_model(input string name, input int n, input logic [31:0] segs,
                           input logic [3:0] bl, input logic [3:0] bk);
    logic [3:0] ea;
    logic [7:0] es;
    repeat (n) begin
      step();
      expect_out(k, segs, bl, bk, ea, es);
      check(name, ea, es);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin
      step();
      check("reset", 4'hF, 8'hFF);
    end
    rst = 1'b0;
    k   = 0;
  endtask

  initial begin
    clk   = 1'b0;
    rst   = 1'b1;
    load  = 1'b0;
    data  = '0;
    dp    = '0;
    blank = '0;
    blink = '0;

    vecs[0] = '{data: 16'h3210, dp: 4'b0000, blank: 4'b0000, segs: 32'hB0A4F9C0};
    vecs[1] = '{data: 16'h7654, dp: 4'b0000, blank: 4'b0000, segs: 32'hF8829299};
    vecs[2] = '{data: 16'hBA98, dp: 4'b0000, blank: 4'b0000, segs: 32'h83889080};
    vecs[3] = '{data: 16'hFEDC, dp: 4'b0000, blank: 4'b0000, segs: 32'h8E86A1C6};
    vecs[4] = '{data: 16'h8888, dp: 4'b0101, blank: 4'b1000, segs: 32'hFF008000};

    // Reset, then scan order with cleared registers.
    do_reset();
    run_model("scan", 34, ALL_C0, 4'b0000, 4'b0000);

    // Decode sweep plus dp/blank; the scan keeps running across loads.
    for (int i = 0; i < 5; i++) begin
      data  = vecs[i].data;
      dp    = vecs[i].dp;
      blank = vecs[i].blank;
      blink = 4'b0000;
      load  = 1'b1;
      step();
      load  = 1'b0;
      run_model($sformatf("vec%0d", i), 16, vecs[i].segs, vecs[i].blank, 4'b0000);
    end

    // Blink on digit 1 across four frames.
    do_reset();
    data  = 16'h0000;
    dp    = 4'b0000;
    blank = 4'b0000;
    blink = 4'b0010;
    load  = 1'b1;
    step();
    check("blink_load", 4'hF, 8'hFF);
    load  = 1'b0;
    blink = 4'b0000;
    run_model("blink", 64, ALL_C0, 4'b0000, 4'b0010);

    // Mid-slot load: new value shows one cycle after the load edge.
    do_reset();
    run_model("mid_pre", 1, ALL_C0, 4'b0000, 4'b0000);
    data = 16'h000F;
    load = 1'b1;
    step();
    check("mid_old", 4'hE, 8'hC0);
    load = 1'b0;
    run_model("mid_new", 16, 32'hC0C0C08E, 4'b0000, 4'b0000);

    // Reset wins over a simultaneous load.
    data = 16'hFFFF;
    dp   = 4'hF;
    load = 1'b1;
    rst  = 1'b1;
    step();
    check("rst_load", 4'hF, 8'hFF);
    rst  = 1'b0;
    load = 1'b0;
    data = 16'h0000;
    dp   = 4'h0;
    k    = 0;
    run_model("restart", 18, ALL_C0, 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
